// File: rtl/phdiff_unwrap.sv
// phdiff_unwrap: unwraps a modulo-2^pw phase difference, rejects implausible jumps as slips,
// and emits block averages of 2^navg accepted samples over a valid/ready handshake.
module phdiff_unwrap #(
    parameter int pw   = 13,
    parameter int ow   = 24,
    parameter int navg = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [pw-1:0]        ph_in,
    input  logic                 ph_stb,
    input  logic                 err_in,
    input  logic                 clr,
    output logic signed [ow-1:0] avg_out,
    output logic                 avg_valid,
    input  logic                 avg_ready,
    output logic [7:0]           slip_cnt,
    output logic [2:0]           status
);
    typedef enum logic {EMPTY, TRACK} state_t;

    localparam logic signed [pw-1:0] lim = pw'(2 ** (pw - 2));

    state_t                    state, state_nxt;
    logic [pw-1:0]             last;
    logic signed [ow-1:0]      unw, unw_nxt, result;
    logic signed [ow+navg-1:0] sum, sum_nxt;
    logic [navg-1:0]           cnt;
    logic signed [pw-1:0]      d;
    logic                      take, in_range, accept, slip, done;
    logic                      overrun, slip_seen, fault_seen;

    assign status = {overrun, slip_seen, fault_seen};

    always_comb begin
        d         = $signed(ph_in - last);
        in_range  = (d <= lim) && (d >= -lim);
        take      = ph_stb && !err_in;
        accept    = take && (state == EMPTY || in_range);
        slip      = take && state == TRACK && !in_range;
        unw_nxt   = state == EMPTY ? $signed(ow'(ph_in)) : unw + ow'(d);
        sum_nxt   = sum + (ow+navg)'(unw_nxt);
        done      = accept && &cnt;
        result    = ow'(sum_nxt >>> navg);
        state_nxt = err_in ? EMPTY : accept ? TRACK : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            last       <= '0;
            unw        <= '0;
            sum        <= '0;
            cnt        <= '0;
            avg_out    <= '0;
            avg_valid  <= 1'b0;
            slip_cnt   <= '0;
            overrun    <= 1'b0;
            slip_seen  <= 1'b0;
            fault_seen <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take)
                last <= ph_in;
            // A fault drops the partial average but leaves any pending result alone
            if (err_in) begin
                sum <= '0;
                cnt <= '0;
            end else if (accept) begin
                unw <= unw_nxt;
                sum <= done ? '0 : sum_nxt;
                cnt <= cnt + 1'b1;
            end
            if (done && (!avg_valid || avg_ready)) begin
                avg_out   <= result;
                avg_valid <= 1'b1;
            end else if (avg_valid && avg_ready) begin
                avg_valid <= 1'b0;
            end
            if (clr) begin
                slip_cnt   <= '0;
                overrun    <= 1'b0;
                slip_seen  <= 1'b0;
                fault_seen <= 1'b0;
            end else begin
                if (done && avg_valid && !avg_ready)
                    overrun <= 1'b1;
                if (slip)
                    slip_seen <= 1'b1;
                if (err_in)
                    fault_seen <= 1'b1;
                if (slip && slip_cnt != 8'hff)
                    slip_cnt <= slip_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_phdiff_unwrap.sv
// tb_phdiff_unwrap: directed vectors with a result scoreboard drained by a handshake monitor.
module tb_phdiff_unwrap;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] ph_in;
    logic        ph_stb, err_in, clr, avg_ready;
    logic [23:0] avg_out;
    logic        avg_valid;
    logic [7:0]  slip_cnt;
    logic [2:0]  status;

    logic [23:0] q[$];
    int n_chk = 0;
    int n_fail = 0;
    int n_pop = 0;

    phdiff_unwrap dut (
        .clk(clk), .rst_n(rst_n), .ph_in(ph_in), .ph_stb(ph_stb), .err_in(err_in),
        .clr(clr), .avg_out(avg_out), .avg_valid(avg_valid), .avg_ready(avg_ready),
        .slip_cnt(slip_cnt), .status(status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && avg_valid && avg_ready) begin
            n_pop++;
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_result: got %0h expected none", avg_out);
            end else begin
                chk("avg_out", {8'h0, avg_out}, {8'h0, q.pop_front()});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strb(input logic [12:0] v);
        ph_in  = v;
        ph_stb = 1'b1;
        idle(1);
        ph_stb = 1'b0;
    endtask

    task automatic strb_n(input logic [12:0] v, input int n);
        for (int i = 0; i < n; i++) strb(v);
    endtask

    task automatic reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
        #1;
        chk(name, q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; ph_in = '0; ph_stb = 1'b0; err_in = 1'b0; clr = 1'b0; avg_ready = 1'b1;
        idle(3);
        chk("rst_valid", avg_valid, 0);
        chk("rst_out", avg_out, 0);
        chk("rst_slip_cnt", slip_cnt, 0);
        chk("rst_status", status, 0);
        rst_n = 1'b1;
        idle(1);

        q.push_back(24'd100);
        strb_n(13'd100, 16);
        chk("t1_valid", avg_valid, 1);
        drain("t1_drain");
        chk("t1_slip_cnt", slip_cnt, 0);
        chk("t1_status", status, 0);
        chk("t1_valid_drop", avg_valid, 0);

        reset();
        q.push_back(24'd8233);
        strb(13'd8100); strb(13'd8150); strb(13'd10);
        strb_n(13'd60, 13);
        drain("t2_drain");
        chk("t2_slip_cnt", slip_cnt, 0);

        reset();
        q.push_back(24'hFFFFFE);
        strb(13'd10);
        strb_n(13'd8190, 15);
        drain("neg_drain");

        reset();
        strb(13'd0); strb(13'd3000);
        chk("t3_slip_cnt", slip_cnt, 1);
        chk("t3_status", status, 3'b010);
        q.push_back(24'd9);
        strb_n(13'd3010, 15);
        drain("t3_drain");

        reset();
        avg_ready = 1'b0;
        q.push_back(24'd200);
        strb_n(13'd200, 16);
        strb_n(13'd300, 16);
        chk("t4_valid_held", avg_valid, 1);
        chk("t4_out_held", avg_out, 200);
        chk("t4_status", status, 3'b100);
        avg_ready = 1'b1;
        idle(1);
        chk("t4_valid_drop", avg_valid, 0);
        drain("t4_drain");

        reset();
        strb_n(13'd500, 7);
        err_in = 1'b1; ph_stb = 1'b1; ph_in = 13'd4000;
        idle(1);
        err_in = 1'b0; ph_stb = 1'b0;
        chk("t5_status", status, 3'b001);
        q.push_back(24'd1000);
        strb_n(13'd1000, 16);
        drain("t5_drain");

        reset();
        strb(13'd0); strb(13'd2048);
        chk("bnd_pos_ok", slip_cnt, 0);
        strb(13'd4097);
        chk("bnd_pos_slip", slip_cnt, 1);
        strb(13'd2049);
        chk("bnd_neg_ok", slip_cnt, 1);

        clr = 1'b1;
        strb(13'd5049);
        clr = 1'b0;
        chk("t6_slip_cnt", slip_cnt, 0);
        chk("t6_status", status, 0);
        strb(13'd0);
        chk("t6_slip_again", slip_cnt, 1);
        chk("t6_status_again", status, 3'b010);
        for (int i = 0; i < 130; i++) begin
            strb(13'd3000);
            strb(13'd0);
        end
        chk("sat_slip_cnt", slip_cnt, 255);

        idle(4);
        chk("pop_count", n_pop, 6);
        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/phdiff_unwrap.md
PHDIFF_UNWRAP -- requirements
Module: phdiff_unwrap

Interface
REQ-001 Parameter pw, default 13: width of wrapped phase-difference input (one full turn = 2^pw counts).
REQ-002 Parameter ow, default 24: width of unwrapped/averaged signed output.
REQ-003 Parameter navg, default 4: log2 of samples per average.
REQ-004 clk  input  1  sole clock (readout/local-bus domain); all logic posedge clk.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 ph_in  input  pw  wrapped phase difference, unsigned, modulo 2^pw.
REQ-007 ph_stb  input  1  one-cycle strobe: ph_in holds a new sample this cycle.
REQ-008 err_in  input  1  tracker fault flag, level.
REQ-009 clr  input  1  one-cycle clear of sticky flags and slip counter.
REQ-010 avg_out  output  ow  signed averaged unwrapped phase.
REQ-011 avg_valid  output  1  avg_out holds an unconsumed result.
REQ-012 avg_ready  input  1  consumer accepts avg_out when avg_valid & avg_ready.
REQ-013 slip_cnt  output  8  count of rejected jumps, saturating at 255.
REQ-014 status  output  3  {overrun, slip_seen, fault_seen} sticky flags.

Function
REQ-015 Two states: EMPTY (no reference sample) and TRACK; reset enters EMPTY.
REQ-016 EMPTY + ph_stb + !err_in: unwrapped <= zero-extended ph_in, last <= ph_in, enter TRACK; no delta applied.
REQ-017 TRACK + ph_stb: d = (ph_in - last) mod 2^pw, interpreted as signed pw-bit; last <= ph_in.
REQ-018 |d| <= 2^(pw-2): unwrapped <= unwrapped + sign-extended d (ow-bit two's-complement wrap, no saturation).
REQ-019 |d| > 2^(pw-2): slip; unwrapped unchanged, sample excluded from average, slip_cnt +1 (saturating), slip_seen set.
REQ-020 Accepted sample (REQ-016/018): sum <= sum + new unwrapped value, sample counter +1; sum width ow+navg.
REQ-021 On 2^navg-th accepted sample: result = (sum incl. this sample) arithmetic-shifted right by navg, truncated to ow; sum and counter restart from zero next cycle.
REQ-022 Result ready with avg_valid low, or avg_valid & avg_ready same cycle: avg_out <= result, avg_valid <= 1 one cycle after the final ph_stb.
REQ-023 Result ready with avg_valid high and avg_ready low: result discarded, avg_out held, overrun set.
REQ-024 avg_valid & avg_ready with no new result: avg_valid <= 0 next cycle.
REQ-025 err_in high on any cycle: fault_seen set; state -> EMPTY, sum and counter cleared; pending avg_out/avg_valid untouched; ph_stb that cycle ignored.
REQ-026 ph_stb while err_in high is discarded; leaving EMPTY requires ph_stb with err_in low.
REQ-027 clr: status and slip_cnt zeroed next cycle; clr wins over simultaneous set events; tracking and averaging unaffected.
REQ-028 ph_stb ignored except as defined; back-to-back ph_stb every cycle supported at full rate.

Reset
REQ-029 rst_n low asynchronously: state EMPTY; unwrapped, last, sum, counter, avg_out = 0; avg_valid = 0; slip_cnt = 0; status = 0.
REQ-030 Reset mid-average discards partial sum; first result after reset needs 2^navg accepted samples.

Verification
REQ-031 Reset, 16 strobes ph_in=100 -> one avg_valid, avg_out=100, slip_cnt=0, status=0.
REQ-032 Strobes 8100,8150,10,60 (pw=13) -> unwrapped 8100,8150,8202,8252; no slip.
REQ-033 Strobes 0 then 3000 -> slip (|d|>2048): slip_cnt=1, status=3'b010, unwrapped stays 0, 3000 becomes last.
REQ-034 avg_ready held low across two completed averages -> first result held, overrun set; ready high -> valid drops next cycle.
REQ-035 err_in pulse after 7 samples -> fault_seen, EMPTY; next 16 clean samples give a fresh average.
REQ-036 clr coincident with a slip -> status=0, slip_cnt=0 next cycle.
